// File: rtl/mult_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_collector_pkg
// Brief    : Widths and constants shared by the multiplier wrapper and collector
// Revision : 1.0
// ============================================================================
package mult_result_collector_pkg;

   localparam int DATA_W      = 32;
   localparam int TAG_W       = 5;
   localparam int MUL_LATENCY = 3;

   // A zero tag marks a pipeline bubble.
   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } result_t;

endpackage
`default_nettype wire

// File: rtl/mult_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_collector_if
// Brief    : Issue, multiplier-result and CDB signals of the result collector
// Revision : 1.0
// ============================================================================
interface mult_result_collector_if;
   import mult_result_collector_pkg::*;

   logic              issue_fire;
   logic              issue_ok;
   logic [DATA_W-1:0] mul_out;
   logic [TAG_W-1:0]  mul_tag;
   logic              cdb_req;
   logic              cdb_grant;
   logic [DATA_W-1:0] cdb_data;
   logic [TAG_W-1:0]  cdb_tag;
   logic              overflow;

   modport slave (
      input  issue_fire, mul_out, mul_tag, cdb_grant,
      output issue_ok, cdb_req, cdb_data, cdb_tag, overflow
   );

   modport master (
      output issue_fire, mul_out, mul_tag, cdb_grant,
      input  issue_ok, cdb_req, cdb_data, cdb_tag, overflow
   );

endinterface
`default_nettype wire

// File: rtl/mult_result_collector_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo
// Brief    : Synchronous DEPTH-entry FIFO of multiplier results, registered head
// Revision : 1.0
// ============================================================================
module result_fifo
   import mult_result_collector_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic    clock,
   input  wire logic    reset,
   input  wire logic    push,
   input  wire logic    pop,
   input  wire result_t din,
   output logic         full,
   output logic         empty,
   output result_t      head
);

   localparam int c_ptr_w = $clog2(DEPTH);

   result_t              r_mem [DEPTH];
   logic [c_ptr_w:0]     r_wr_ptr;
   logic [c_ptr_w:0]     r_rd_ptr;
   logic                 w_do_pop;
   logic                 w_do_push;

   // Extra pointer MSB tells a full buffer from an empty one.
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                  (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);

   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   assign head = r_mem[r_rd_ptr[c_ptr_w-1:0]];

   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[c_ptr_w-1:0]] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mult_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mult_result_collector
// Brief    : Buffers multiplier results for the CDB and meters issue by credits
// Revision : 1.0
// ============================================================================
module mult_result_collector
   import mult_result_collector_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = MUL_LATENCY
) (
   input  wire logic               clock,
   input  wire logic               reset,
   mult_result_collector_if.slave  bus
);

   localparam int                    c_cred_w  = $clog2(DEPTH + 1);
   localparam int                    c_drain_w = $clog2(LATENCY + 1);
   localparam logic [c_cred_w-1:0]   c_cred_max = c_cred_w'(DEPTH);
   localparam logic [c_drain_w-1:0]  c_drain_init = c_drain_w'(LATENCY);

   logic [c_drain_w-1:0] r_drain_cnt;
   logic [c_cred_w-1:0]  r_credits;
   logic [c_cred_w-1:0]  w_credits_next;
   logic                 r_overflow;

   logic    w_draining;
   logic    w_capture;
   logic    w_pop;
   logic    w_issue_ok;
   logic    w_issue_acc;
   logic    w_issue_err;
   logic    w_full;
   logic    w_empty;
   result_t w_din;
   result_t w_head;

   assign w_draining  = (r_drain_cnt != '0);
   assign w_capture   = (bus.mul_tag != TAG_NONE) && !w_draining;
   assign w_pop       = !w_empty && bus.cdb_grant;
   assign w_issue_ok  = !w_draining && (r_credits < c_cred_max);
   assign w_issue_acc = bus.issue_fire && w_issue_ok;
   assign w_issue_err = bus.issue_fire && !w_issue_ok;
   assign w_din       = '{data: bus.mul_out, tag: bus.mul_tag};

   result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_capture),
      .pop   (w_pop),
      .din   (w_din),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   // The multiplier pipeline is not reset, so stale tags are ignored for LATENCY cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_drain_cnt <= c_drain_init;
      end else if (w_draining) begin
         r_drain_cnt <= r_drain_cnt - 1'b1;
      end
   end

   always_comb begin
      w_credits_next = r_credits;
      if (w_issue_acc && !w_pop) begin
         w_credits_next = r_credits + c_cred_w'(1);
      end else if (!w_issue_acc && w_pop && (r_credits != '0)) begin
         w_credits_next = r_credits - c_cred_w'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_credits  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_credits <= w_credits_next;
         if ((w_capture && w_full && !w_pop) || w_issue_err) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign bus.issue_ok = w_issue_ok;
   assign bus.cdb_req  = !w_empty;
   assign bus.cdb_data = w_empty ? '0 : w_head.data;
   assign bus.cdb_tag  = w_empty ? TAG_NONE : w_head.tag;
   assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mult_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_result_collector
// Brief    : Directed scoreboard bench for the multiplier result collector
// Revision : 1.0
// ============================================================================
module tb_mult_result_collector;
   import mult_result_collector_pkg::*;

   logic clock = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   mult_result_collector_if bus ();

   mult_result_collector #(
      .DEPTH   (4),
      .LATENCY (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Three-stage multiplier stand-in with no reset, plus a direct injection path.
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] in_data;
   logic              force_en;
   logic [TAG_W-1:0]  force_tag;
   logic [DATA_W-1:0] force_data;
   logic [TAG_W-1:0]  pipe_tag  [3] = '{default: '0};
   logic [DATA_W-1:0] pipe_data [3] = '{default: '0};

   always @(posedge clock) begin
      pipe_tag[0]  <= bus.issue_fire ? in_tag : '0;
      pipe_data[0] <= in_data;
      pipe_tag[1]  <= pipe_tag[0];
      pipe_data[1] <= pipe_data[0];
      pipe_tag[2]  <= pipe_tag[1];
      pipe_data[2] <= pipe_data[1];
   end

   assign bus.mul_tag = force_en ? force_tag  : pipe_tag[2];
   assign bus.mul_out = force_en ? force_data : pipe_data[2];

   result_t exp_q [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      check("issue_ok_before_issue", 64'(bus.issue_ok), 64'd1);
      bus.issue_fire = 1'b1;
      in_tag         = t;
      in_data        = d;
      exp_q.push_back('{data: d, tag: t});
      @(negedge clock);
      bus.issue_fire = 1'b0;
      in_tag         = '0;
   endtask

   task automatic grant_head(input string tag);
      result_t e;
      check({tag, "_req"}, 64'(bus.cdb_req), 64'd1);
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_tag"},  64'(bus.cdb_tag),  64'(e.tag));
         check({tag, "_data"}, 64'(bus.cdb_data), 64'(e.data));
      end
      bus.cdb_grant = 1'b1;
      @(negedge clock);
      bus.cdb_grant = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      bus.issue_fire = 1'b0;
      bus.cdb_grant  = 1'b0;
      in_tag         = '0;
      in_data        = '0;
      force_en       = 1'b0;
      force_tag      = '0;
      force_data     = '0;

      // Reset and drain with a stale tag on the multiplier output
      repeat (2) @(negedge clock);
      check("rst_req",      64'(bus.cdb_req),  64'd0);
      check("rst_data",     64'(bus.cdb_data), 64'd0);
      check("rst_tag",      64'(bus.cdb_tag),  64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_issue_ok", 64'(bus.issue_ok), 64'd0);
      reset      = 1'b0;
      force_en   = 1'b1;
      force_tag  = 5'd7;
      force_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         check("drain_issue_ok", 64'(bus.issue_ok), 64'd0);
         check("drain_req",      64'(bus.cdb_req),  64'd0);
         @(negedge clock);
      end
      force_en = 1'b0;
      check("post_drain_issue_ok", 64'(bus.issue_ok), 64'd1);
      check("post_drain_req",      64'(bus.cdb_req),  64'd0);

      // Single result, no bypass from mul_tag to cdb_req
      issue(5'd3, 32'h0000_0F0F);
      repeat (2) @(negedge clock);
      check("no_bypass_req", 64'(bus.cdb_req), 64'd0);
      @(negedge clock);
      grant_head("single");
      check("single_req_after", 64'(bus.cdb_req), 64'd0);
      check("single_credits",   64'(dut.r_credits), 64'd0);
      check("single_issue_ok",  64'(bus.issue_ok), 64'd1);

      // Back-pressure: four issues exhaust the credit pool
      for (int t = 1; t <= 4; t++) begin
         issue(TAG_W'(t), 32'h1111_1111 * DATA_W'(t));
      end
      check("bp_issue_ok_low", 64'(bus.issue_ok), 64'd0);
      repeat (3) @(negedge clock);
      check("bp_full",     64'(dut.w_full),   64'd1);
      check("bp_overflow", 64'(bus.overflow), 64'd0);
      check("bp_issue_ok", 64'(bus.issue_ok), 64'd0);
      for (int i = 0; i < 4; i++) grant_head("bp_drain");
      check("bp_req_after",      64'(bus.cdb_req),  64'd0);
      check("bp_issue_ok_after", 64'(bus.issue_ok), 64'd1);

      // Full FIFO with a capture and a pop in the same cycle
      for (int t = 5; t <= 8; t++) begin
         issue(TAG_W'(t), 32'hA000_0000 + DATA_W'(t));
      end
      repeat (3) @(negedge clock);
      check("full2_full", 64'(dut.w_full), 64'd1);
      force_en   = 1'b1;
      force_tag  = 5'd9;
      force_data = 32'h9999_0009;
      exp_q.push_back('{data: 32'h9999_0009, tag: 5'd9});
      grant_head("simul");
      force_en = 1'b0;
      check("simul_overflow", 64'(bus.overflow), 64'd0);
      check("simul_full",     64'(dut.w_full),   64'd1);
      check("simul_head",     64'(bus.cdb_tag),  64'd6);

      // Capture into a full FIFO with no pop is dropped and flagged
      force_en   = 1'b1;
      force_tag  = 5'd10;
      force_data = 32'h1010_1010;
      @(negedge clock);
      force_en = 1'b0;
      check("ovf_set",  64'(bus.overflow), 64'd1);
      check("ovf_head", 64'(bus.cdb_tag),  64'd6);
      for (int i = 0; i < 4; i++) grant_head("ovf_drain");
      check("ovf_req_after", 64'(bus.cdb_req),  64'd0);
      check("ovf_sticky1",   64'(bus.overflow), 64'd1);
      issue(5'd11, 32'h0B0B_0B0B);
      repeat (3) @(negedge clock);
      grant_head("ovf_traffic");
      check("ovf_sticky2", 64'(bus.overflow), 64'd1);

      // Reset with two results buffered and one still in the multiplier
      issue(5'd12, 32'h0C0C_0C0C);
      issue(5'd13, 32'h0D0D_0D0D);
      repeat (3) @(negedge clock);
      check("mid_buffered", 64'(bus.cdb_req), 64'd1);
      issue(5'd14, 32'h0E0E_0E0E);
      reset = 1'b1;
      @(negedge clock);
      exp_q.delete();
      check("mid_rst_req",      64'(bus.cdb_req),   64'd0);
      check("mid_rst_tag",      64'(bus.cdb_tag),   64'd0);
      check("mid_rst_credits",  64'(dut.r_credits), 64'd0);
      check("mid_rst_issue_ok", 64'(bus.issue_ok),  64'd0);
      check("mid_rst_overflow", 64'(bus.overflow),  64'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("mid_drain_req",      64'(bus.cdb_req),  64'd0);
         check("mid_drain_issue_ok", 64'(bus.issue_ok), 64'd0);
         @(negedge clock);
      end
      check("mid_final_req",      64'(bus.cdb_req),  64'd0);
      check("mid_final_issue_ok", 64'(bus.issue_ok), 64'd1);
      @(negedge clock);
      check("mid_stale_ignored", 64'(bus.cdb_req), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mult_result_collector.md
Name: mult_result_collector

Overview:
- Sits on the far side of the 3-stage multiplier wrapper and consumes its (out, tag_out) stream.
- Buffers each completed product in a small FIFO and presents it to the common data bus (CDB) through a req/grant handshake.
- The multiplier cannot stall, so the block also runs a credit counter. It tells the issue stage when a multiply may enter the multiplier without risking buffer overflow.

Parameters:
- DEPTH, 4, result FIFO entries; also the total credit pool (power of two, 2..16).
- LATENCY, 3, multiplier issue-to-result latency in cycles.
- DATA_W, 32, product width.
- TAG_W, 5, tag width. Tag value 0 means "no instruction" (bubble).

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- issue_fire  in  1  a multiply enters the multiplier this cycle (its tag is nonzero).
- issue_ok  out  1  a credit is free; the issue stage may assert issue_fire.
- mul_out  in  DATA_W  product from the multiplier.
- mul_tag  in  TAG_W  tag from the multiplier; nonzero means the result is valid.
- cdb_req  out  1  FIFO head is valid and is requesting the CDB.
- cdb_grant  in  1  the CDB arbiter accepts the head this cycle.
- cdb_data  out  DATA_W  head product.
- cdb_tag  out  TAG_W  head tag. Forced to 0 when the FIFO is empty.
- overflow  out  1  sticky error flag: a result arrived while the FIFO was full.

Behaviour:
- Reset:
  - FIFO empty, pointers 0, credits 0, overflow 0, drain counter loaded with LATENCY.
  - Outputs after reset: cdb_req 0, cdb_data 0, cdb_tag 0, issue_ok 0 while draining.
- Drain after reset:
  - The multiplier pipeline has no reset, so stale tags may still emerge.
  - For LATENCY cycles after reset deasserts, mul_tag is ignored and issue_ok is 0.
  - The drain counter decrements each cycle. At 0, normal operation begins.
  - Reset asserted mid-operation restarts the drain period. Buffered and in-flight results are discarded.
- Capture:
  - When mul_tag != 0 and not draining, write {mul_out, mul_tag} at the write pointer and increment it.
  - Pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.
- Presentation:
  - Registered FIFO only, no bypass. A result on mul_tag in cycle N can drive cdb_req no earlier than cycle N+1.
  - cdb_req = not empty. cdb_data and cdb_tag show the head entry and stay stable until it is popped.
- Pop:
  - A pop happens when cdb_req && cdb_grant. The read pointer advances next edge.
  - cdb_grant with cdb_req = 0 is ignored.
- Simultaneous capture and pop:
  - Both take effect. Occupancy is unchanged, and a full FIFO stays full without overflowing.
- Credits:
  - credits_next = credits + issue_fire - pop. Range 0..DEPTH.
  - issue_ok = !draining && credits < DEPTH. It depends only on the registered count, with no combinational path from cdb_grant.
  - issue_fire while issue_ok = 0 is a protocol error: it is ignored, the count saturates at DEPTH, and overflow is set.
- Overflow:
  - A capture while full with no pop drops the result and sets overflow.
  - overflow stays set until reset. It cannot occur with a correct issuer.
- Throughput: one capture and one pop per cycle, sustained.

Decomposition:
- Shared package / include: TAG_W, DATA_W, the bubble tag constant TAG_NONE = 0, and MUL_LATENCY = 3. The multiplier wrapper and this block use the same values.
- One natural sub-module, result_fifo:
  - DEPTH x (DATA_W+TAG_W) synchronous FIFO with push, pop, full, empty and head outputs.
  - The credit counter, drain counter and overflow logic stay in the top level.

Test Plan:
- Reset drain: hold reset 2 cycles, then release with mul_tag = 5'd7 for 3 cycles → nothing captured, issue_ok = 0 for 3 cycles, then issue_ok = 1; cdb_req stays 0.
- Single result: issue_fire 1 cycle, then mul_tag = 3, mul_out = 32'h0000_0F0F 3 cycles later → next cycle cdb_req = 1, cdb_tag = 3, cdb_data = 32'h0000_0F0F; grant once → cdb_req = 0, credits back to 0.
- Back-pressure: cdb_grant held 0, issue 4 multiplies with tags 1..4 → issue_ok drops after the 4th issue; all 4 buffered, overflow = 0; grant 4 cycles → tags 1, 2, 3, 4 appear in order, issue_ok returns to 1.
- Full with simultaneous events: FIFO full, mul_tag = 9 arrives in the same cycle as a grant → tag 9 stored, head advances, overflow stays 0.
- Overflow: force a capture with the FIFO full and no grant → result dropped, overflow = 1 and sticky through further traffic until reset.
- Mid-operation reset: 2 entries buffered and 1 in flight; assert reset → cdb_req = 0 next cycle, in-flight tag ignored during drain, credits = 0.
